// File: rtl/rst_sequencer.sv
// rtl/rst_sequencer.sv - ordered SoC reset release: bus/peripherals, then core, then fetch enable
module rst_sequencer #(
   parameter int SYNC_STAGES = 2,
   parameter int LOCK_STABLE = 16,
   parameter int SYS_HOLD    = 32,
   parameter int CORE_DELAY  = 8,
   parameter int FETCH_DELAY = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pll_locked_i,
   input  logic       sw_rst_req_i,
   output logic       rst_sys_n_o,
   output logic       rst_core_n_o,
   output logic       fetch_enable_o,
   output logic [1:0] rst_cause_o
);

   localparam int MAX_A = (LOCK_STABLE > SYS_HOLD) ? LOCK_STABLE : SYS_HOLD;
   localparam int MAX_B = (CORE_DELAY > FETCH_DELAY) ? CORE_DELAY : FETCH_DELAY;
   localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int CW    = $clog2(MAX_P + 1);

   localparam logic [CW-1:0] LOAD_LOCK  = CW'(LOCK_STABLE - 1);
   localparam logic [CW-1:0] LOAD_SYS   = CW'(SYS_HOLD - 1);
   localparam logic [CW-1:0] LOAD_CORE  = CW'(CORE_DELAY - 1);
   localparam logic [CW-1:0] LOAD_FETCH = CW'(FETCH_DELAY - 1);

   localparam logic [1:0] CAUSE_PAD  = 2'b00;
   localparam logic [1:0] CAUSE_LOCK = 2'b01;
   localparam logic [1:0] CAUSE_SW   = 2'b10;

   typedef enum logic [2:0] {
      WAIT_LOCK,
      HOLD_SYS,
      HOLD_CORE,
      FETCH_WAIT,
      RUN
   } state_t;

   state_t                 state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [1:0]             cause_q, cause_d;
   logic                   sys_n_q, sys_n_d;
   logic                   core_n_q, core_n_d;
   logic                   fetch_q, fetch_d;
   logic                   lock_s;

   assign lock_s = sync_q[SYNC_STAGES-1];

   // The counter holds "cycles remaining minus one"; expiry is cnt_q == 0.
   // Clearing it on reset is safe because lock_s is forced low for the first
   // SYNC_STAGES edges, which reloads it before any counting starts.
   always_comb begin
      sync_d  = {sync_q[SYNC_STAGES-2:0], pll_locked_i};
      state_d = state_q;
      cnt_d   = cnt_q;
      cause_d = cause_q;
      case (state_q)
         WAIT_LOCK: begin
            if (!lock_s) begin
               cnt_d = LOAD_LOCK;
            end else if (cnt_q == '0) begin
               state_d = HOLD_SYS;
               cnt_d   = LOAD_SYS;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: begin
            if (!lock_s) begin
               state_d = WAIT_LOCK;
               cnt_d   = LOAD_LOCK;
               cause_d = CAUSE_LOCK;
            end else if (state_q == RUN) begin
               if (sw_rst_req_i) begin
                  state_d = HOLD_SYS;
                  cnt_d   = LOAD_SYS;
                  cause_d = CAUSE_SW;
               end
            end else if (cnt_q == '0) begin
               case (state_q)
                  HOLD_SYS: begin
                     state_d = HOLD_CORE;
                     cnt_d   = LOAD_CORE;
                  end
                  HOLD_CORE: begin
                     state_d = FETCH_WAIT;
                     cnt_d   = LOAD_FETCH;
                  end
                  default: begin
                     state_d = RUN;
                     cnt_d   = '0;
                  end
               endcase
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
      endcase
      sys_n_d  = (state_d == HOLD_CORE) || (state_d == FETCH_WAIT) || (state_d == RUN);
      core_n_d = (state_d == FETCH_WAIT) || (state_d == RUN);
      fetch_d  = (state_d == RUN);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= WAIT_LOCK;
         cnt_q    <= '0;
         sync_q   <= '0;
         cause_q  <= CAUSE_PAD;
         sys_n_q  <= 1'b0;
         core_n_q <= 1'b0;
         fetch_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         sync_q   <= sync_d;
         cause_q  <= cause_d;
         sys_n_q  <= sys_n_d;
         core_n_q <= core_n_d;
         fetch_q  <= fetch_d;
      end
   end

   assign rst_sys_n_o    = sys_n_q;
   assign rst_core_n_o   = core_n_q;
   assign fetch_enable_o = fetch_q;
   assign rst_cause_o    = cause_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// tb/tb_rst_sequencer.sv - directed bench for rst_sequencer release timing and reset cause
module tb_rst_sequencer;

   localparam int CORE_GAP  = 8;
   localparam int FETCH_GAP = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       pll_locked_i;
   logic       sw_rst_req_i;
   logic       rst_sys_n_o;
   logic       rst_core_n_o;
   logic       fetch_enable_o;
   logic [1:0] rst_cause_o;

   int n_checks = 0;
   int n_errors = 0;

   rst_sequencer dut (
      .clk           (clk),
      .rst           (rst),
      .pll_locked_i  (pll_locked_i),
      .sw_rst_req_i  (sw_rst_req_i),
      .rst_sys_n_o   (rst_sys_n_o),
      .rst_core_n_o  (rst_core_n_o),
      .fetch_enable_o(fetch_enable_o),
      .rst_cause_o   (rst_cause_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Edges counted from the next rising edge as 1; sys rises on edge sys_e.
   task automatic expect_seq(input string tag, input int sys_e, input logic [1:0] cause);
      step(sys_e - 1);
      check({tag, "_sys_early"}, rst_sys_n_o, 1'b0);
      check({tag, "_core_early"}, rst_core_n_o, 1'b0);
      check({tag, "_fetch_early"}, fetch_enable_o, 1'b0);
      check({tag, "_cause_a"}, rst_cause_o, cause);
      step(1);
      check({tag, "_sys_rise"}, rst_sys_n_o, 1'b1);
      check({tag, "_core_held"}, rst_core_n_o, 1'b0);
      step(CORE_GAP - 1);
      check({tag, "_core_early2"}, rst_core_n_o, 1'b0);
      step(1);
      check({tag, "_core_rise"}, rst_core_n_o, 1'b1);
      check({tag, "_fetch_held"}, fetch_enable_o, 1'b0);
      step(FETCH_GAP - 1);
      check({tag, "_fetch_early2"}, fetch_enable_o, 1'b0);
      step(1);
      check({tag, "_fetch_rise"}, fetch_enable_o, 1'b1);
      check({tag, "_cause_b"}, rst_cause_o, cause);
   endtask

   task automatic check_all_low(input string tag, input logic [1:0] cause);
      check({tag, "_sys"}, rst_sys_n_o, 1'b0);
      check({tag, "_core"}, rst_core_n_o, 1'b0);
      check({tag, "_fetch"}, fetch_enable_o, 1'b0);
      check({tag, "_cause"}, rst_cause_o, cause);
   endtask

   initial begin
      rst          = 1'b1;
      pll_locked_i = 1'b1;
      sw_rst_req_i = 1'b0;
      step(3);
      check_all_low("reset", 2'b00);

      // Power-on with lock already stable
      rst = 1'b0;
      expect_seq("por", 50, 2'b00);

      // Lock loss in RUN: two sync edges, then the state edge
      step(5);
      pll_locked_i = 1'b0;
      step(2);
      check("loss_still_run", fetch_enable_o, 1'b1);
      step(1);
      check_all_low("loss", 2'b01);
      pll_locked_i = 1'b1;
      expect_seq("relock", 50, 2'b01);

      // Software reset from RUN skips lock qualification
      step(3);
      sw_rst_req_i = 1'b1;
      step(1);
      sw_rst_req_i = 1'b0;
      check_all_low("swrst", 2'b10);
      expect_seq("swrst", 32, 2'b10);

      // Software request during HOLD_CORE is ignored
      step(2);
      sw_rst_req_i = 1'b1;
      step(1);
      sw_rst_req_i = 1'b0;
      step(32);
      check("hc_entry_sys", rst_sys_n_o, 1'b1);
      step(2);
      sw_rst_req_i = 1'b1;
      step(1);
      sw_rst_req_i = 1'b0;
      check("hc_ign_sys", rst_sys_n_o, 1'b1);
      check("hc_ign_core", rst_core_n_o, 1'b0);
      check("hc_ign_cause", rst_cause_o, 2'b10);
      step(4);
      check("hc_core_early", rst_core_n_o, 1'b0);
      step(1);
      check("hc_core_rise", rst_core_n_o, 1'b1);
      step(4);
      check("hc_fetch_rise", fetch_enable_o, 1'b1);

      // Lock loss and software request in the same cycle: lock loss wins
      step(2);
      pll_locked_i = 1'b0;
      step(2);
      sw_rst_req_i = 1'b1;
      step(1);
      sw_rst_req_i = 1'b0;
      check_all_low("simul", 2'b01);
      pll_locked_i = 1'b1;
      expect_seq("simul", 50, 2'b01);

      // Asynchronous reset asserted between edges during HOLD_CORE
      step(2);
      sw_rst_req_i = 1'b1;
      step(1);
      sw_rst_req_i = 1'b0;
      step(35);
      check("async_pre_sys", rst_sys_n_o, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      check_all_low("async", 2'b00);
      @(posedge clk);
      #1;
      rst = 1'b0;
      expect_seq("async_rel", 50, 2'b00);

      // Lock bounce low for edges 10..12 after release
      rst = 1'b1;
      step(2);
      rst = 1'b0;
      step(9);
      pll_locked_i = 1'b0;
      step(3);
      check_all_low("bounce", 2'b00);
      pll_locked_i = 1'b1;
      expect_seq("bounce", 50, 2'b00);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
